// File: rtl/vga_capture_monitor.sv
// VGA receive monitor: recovers x/y, measures line/frame timing, locks on stable
// geometry and reports a CRC-16-CCITT of each good frame's pixel data.
module vga_capture_monitor #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter bit SYNC_POL    = 1'b0,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        de,
   input  logic [3:0]  r,
   input  logic [3:0]  g,
   input  logic [3:0]  b,
   output logic        pix_valid,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic [10:0] h_total,
   output logic [10:0] v_total,
   output logic        locked,
   output logic [15:0] frame_crc,
   output logic        crc_valid,
   output logic        err
);

   localparam logic [10:0] CNT_MAX = 11'h7FF;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] rgb;
   } vid_s;

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   function automatic logic [10:0] inc_sat(input logic [10:0] v);
      return (v == CNT_MAX) ? v : v + 11'd1;
   endfunction

   // 12 message bits per clock, MSB first, poly 0x1021
   function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] n;
      n = c;
      for (int i = 11; i >= 0; i--)
         n = {n[14:0], 1'b0} ^ ((n[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return n;
   endfunction

   vid_s        s1;
   logic        hs_prev, vs_prev, de_prev;
   logic        h_edge, v_edge, de_rise, de_fall, line_bad, frame_good;
   logic        bad;
   logic [10:0] hcnt, vcnt;
   logic [15:0] crc;
   logic [2:0]  good_cnt;
   state_t      state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1      <= '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0, rgb: 12'h000};
         hs_prev <= ~SYNC_POL;
         vs_prev <= ~SYNC_POL;
         de_prev <= 1'b0;
      end else begin
         s1      <= '{hs: hsync, vs: vsync, de: de, rgb: {r, g, b}};
         hs_prev <= s1.hs;
         vs_prev <= s1.vs;
         de_prev <= s1.de;
      end
   end

   always_comb begin
      h_edge     = (s1.hs == SYNC_POL) && (hs_prev != SYNC_POL);
      v_edge     = (s1.vs == SYNC_POL) && (vs_prev != SYNC_POL);
      de_rise    = s1.de && !de_prev;
      de_fall    = !s1.de && de_prev;
      // x still holds the index of the line's last pixel on the de falling clock
      line_bad   = de_fall && (x != 11'(H_ACTIVE - 1));
      frame_good = (y == 11'(V_ACTIVE)) && !bad;
   end

   // A vsync edge closes the frame before this clock's pixel/line event, so that
   // event is accounted to the new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_valid <= 1'b0;
         x         <= '0;
         y         <= '0;
         bad       <= 1'b0;
         crc       <= CRC_INIT;
         hcnt      <= '0;
         vcnt      <= '0;
         h_total   <= '0;
         v_total   <= '0;
      end else begin
         pix_valid <= s1.de;
         if (de_rise)    x <= '0;
         else if (s1.de) x <= inc_sat(x);

         if (h_edge) begin
            h_total <= hcnt;
            hcnt    <= 11'd1;
         end else begin
            hcnt    <= inc_sat(hcnt);
         end

         if (v_edge) begin
            y       <= de_fall ? 11'd1 : 11'd0;
            bad     <= line_bad;
            crc     <= s1.de ? crc12(CRC_INIT, s1.rgb) : CRC_INIT;
            v_total <= vcnt;
            vcnt    <= h_edge ? 11'd1 : 11'd0;
         end else begin
            if (de_fall) y <= inc_sat(y);
            bad     <= bad | line_bad;
            if (s1.de) crc <= crc12(crc, s1.rgb);
            if (h_edge) vcnt <= inc_sat(vcnt);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SEARCH;
         good_cnt  <= '0;
         locked    <= 1'b0;
         frame_crc <= '0;
         crc_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         crc_valid <= 1'b0;
         err       <= 1'b0;
         if (v_edge) begin
            case (state)
               SEARCH: begin
                  state    <= MEASURE;
                  good_cnt <= '0;
               end
               MEASURE: begin
                  if (!frame_good) begin
                     good_cnt <= '0;
                  end else if (good_cnt + 3'd1 == 3'(LOCK_FRAMES)) begin
                     state     <= LOCKED;
                     locked    <= 1'b1;
                     good_cnt  <= '0;
                     frame_crc <= crc;
                     crc_valid <= 1'b1;
                  end else begin
                     good_cnt <= good_cnt + 3'd1;
                  end
               end
               LOCKED: begin
                  if (frame_good) begin
                     frame_crc <= crc;
                     crc_valid <= 1'b1;
                  end else begin
                     err    <= 1'b1;
                     locked <= 1'b0;
                     state  <= SEARCH;
                  end
               end
               default: begin
                  state  <= SEARCH;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
